// File: rtl/hwjsoc_dct_pkg.sv
// Shared constants and state encoding for the DCT trace atom packer.
// Atom codes, frame geometry and the packer FSM states live here.
package hwjsoc_dct_pkg;

  localparam int ATOM_W    = 2;
  localparam int MAX_ATOMS = 15;
  localparam int BUF_W     = ATOM_W * MAX_ATOMS;
  localparam int CNT_W     = 4;

  localparam logic [ATOM_W-1:0] ATOM_NT  = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_TK  = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_EXC = 2'b11;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } dct_state_e;

  // 00 is not a legal atom code and must never reach the accumulator.
  function automatic logic atom_is_legal(input logic [ATOM_W-1:0] a);
    return a != 2'b00;
  endfunction

endpackage

// File: rtl/hwjsoc_dct_frame_slot.sv
// One-entry valid/ready output register holding a closed trace frame.
// A load always wins; otherwise the entry empties once the consumer takes it.
module hwjsoc_dct_frame_slot
  import hwjsoc_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ready,
  output logic             valid,
  output logic [BUF_W-1:0] buffer,
  output logic [CNT_W-1:0] count,
  output logic             slot_free
);

  assign slot_free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid  <= 1'b0;
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      buffer <= load_buffer;
      count  <= load_count;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/hwjsoc_cpu_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit frames; the source never stalls, so atoms
// arriving while a closed frame waits for the slot are dropped and flagged. Optional DCT_DROP_CNT_EN adds drop_count.
module hwjsoc_cpu_dct_packer
  import hwjsoc_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  frame_buffer,
  output logic [CNT_W-1:0]  frame_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow
`ifdef DCT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  dct_state_e       state;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;

  logic             atom_ok;
  logic             slot_free;
  logic [BUF_W-1:0] ins_buf;
  logic [CNT_W-1:0] ins_cnt;
  logic             close_fill;
  logic             hold_done;
  logic             load;
  logic [BUF_W-1:0] load_buffer;
  logic [CNT_W-1:0] load_count;
  logic             drop;

  assign atom_ok = atom_valid && atom_is_legal(atom);

  // The same-cycle atom is inserted before deciding whether the frame closes.
  always_comb begin
    ins_buf = acc;
    ins_cnt = cnt;
    if (atom_ok) begin
      ins_buf = acc | (BUF_W'(atom) << (ATOM_W * int'(cnt)));
      ins_cnt = cnt + 1'b1;
    end
  end

  assign close_fill  = (state == FILL) &&
                       ((ins_cnt == CNT_W'(MAX_ATOMS)) || (flush && (ins_cnt != '0)));
  assign hold_done   = (state == HOLD) && slot_free &&
                       (flush_pend || (cnt == CNT_W'(MAX_ATOMS)));
  assign load        = (close_fill && slot_free) || hold_done;
  assign load_buffer = (state == FILL) ? ins_buf : acc;
  assign load_count  = (state == FILL) ? ins_cnt : cnt;
  assign drop        = (state == HOLD) && atom_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FILL;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (close_fill && !slot_free) begin
            state      <= HOLD;
            acc        <= ins_buf;
            cnt        <= ins_cnt;
            flush_pend <= flush;
          end else if (close_fill) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= ins_buf;
            cnt <= ins_cnt;
          end
        end
        HOLD: begin
          if (hold_done) begin
            state      <= FILL;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
          end
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef DCT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (ovf_clr) begin
      drop_count <= '0;
    end
  end
`endif

  assign dct_buffer = acc;
  assign dct_count  = cnt;

  hwjsoc_dct_frame_slot u_frame_slot (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_buffer (load_buffer),
    .load_count  (load_count),
    .ready       (frame_ready),
    .valid       (frame_valid),
    .buffer      (frame_buffer),
    .count       (frame_count),
    .slot_free   (slot_free)
  );

endmodule

// File: tb/tb_hwjsoc_cpu_dct_packer.sv
// Self-checking bench for hwjsoc_cpu_dct_packer: directed scenarios plus random
// traffic compared each cycle against an atom-list reference model.
module tb_hwjsoc_cpu_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        ovf_clr;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_buffer;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
`ifdef DCT_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  always #5 clk = ~clk;

  hwjsoc_cpu_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_buffer (frame_buffer),
    .frame_count  (frame_count),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow)
`ifdef DCT_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  int vectorCount = 0;
  int failCount   = 0;

  // Reference model: the open frame is a list of atoms; "closed" means it is
  // complete and waiting for the output slot, so new atoms get lost.
  logic [1:0]  mAtoms[15];
  int          mCnt;
  bit          mClosed;
  bit          mSlotValid;
  logic [29:0] mSlotBuf;
  int          mSlotCnt;
  bit          mOvf;
  int          mDrops;

  function automatic logic [29:0] packModel();
    logic [29:0] r;
    r = '0;
    for (int k = 0; k < mCnt; k++) r = r | (30'(mAtoms[k]) << (2 * k));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelStep(input bit av, input logic [1:0] a, input bit fl, input bit rdy, input bit clr);
    bit legal, slotFree, xfer, dropped;
    legal    = av && (a != 2'b00);
    slotFree = !mSlotValid || rdy;
    xfer     = 0;
    dropped  = 0;
    if (mClosed) begin
      dropped = legal;
      xfer    = slotFree;
    end else begin
      if (legal) begin
        mAtoms[mCnt] = a;
        mCnt++;
      end
      if (mCnt == 15 || (fl && mCnt > 0)) begin
        if (slotFree) xfer = 1;
        else mClosed = 1;
      end
    end
    if (xfer) begin
      mSlotValid = 1;
      mSlotBuf   = packModel();
      mSlotCnt   = mCnt;
      mCnt       = 0;
      mClosed    = 0;
    end else if (mSlotValid && rdy) begin
      mSlotValid = 0;
    end
    if (dropped) begin
      mOvf = 1;
      if (mDrops < 255) mDrops++;
    end else if (clr) begin
      mOvf   = 0;
      mDrops = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("frame_valid", 32'(frame_valid), 32'(mSlotValid));
    if (mSlotValid) begin
      checkOutput("frame_buffer", 32'(frame_buffer), 32'(mSlotBuf));
      checkOutput("frame_count", 32'(frame_count), 32'(mSlotCnt));
    end
    checkOutput("dct_count", 32'(dct_count), 32'(mCnt));
    checkOutput("dct_buffer", 32'(dct_buffer), 32'(packModel()));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
`ifdef DCT_DROP_CNT_EN
    checkOutput("drop_count", 32'(drop_count), 32'(mDrops));
`endif
  endtask

  task automatic applyStimulus(input bit av, input logic [1:0] a, input bit fl, input bit rdy, input bit clr);
    atom_valid  = av;
    atom        = a;
    flush       = fl;
    frame_ready = rdy;
    ovf_clr     = clr;
    @(posedge clk);
    #1;
    modelStep(av, a, fl, rdy, clr);
    checkAll();
  endtask

  task automatic applyReset();
    reset_n     = 1'b0;
    atom_valid  = 1'b0;
    atom        = 2'b00;
    flush       = 1'b0;
    frame_ready = 1'b0;
    ovf_clr     = 1'b0;
    @(posedge clk);
    #1;
    mCnt = 0; mClosed = 0; mSlotValid = 0; mSlotBuf = '0; mSlotCnt = 0; mOvf = 0; mDrops = 0;
    checkOutput("rst_frame_valid", 32'(frame_valid), 32'd0);
    checkOutput("rst_frame_buffer", 32'(frame_buffer), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("rst_dct_count", 32'(dct_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
`ifdef DCT_DROP_CNT_EN
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    reset_n = 1'b1;
  endtask

  initial begin
    int readyPct;
    applyReset();
    applyReset();

    // 15 taken atoms with the consumer ready
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b10, 0, 1, 0);
    checkOutput("t1_valid", 32'(frame_valid), 32'd1);
    checkOutput("t1_buf", 32'(frame_buffer), 32'h2AAAAAAA);
    checkOutput("t1_cnt", 32'(frame_count), 32'd15);
    checkOutput("t1_dct_cnt", 32'(dct_count), 32'd0);

    // NT, TK, EXC then flush; then an empty flush
    applyStimulus(1, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b10, 0, 1, 0);
    applyStimulus(1, 2'b11, 0, 1, 0);
    applyStimulus(0, 2'b00, 1, 1, 0);
    checkOutput("t2_buf", 32'(frame_buffer), 32'h39);
    checkOutput("t2_cnt", 32'(frame_count), 32'd3);
    applyStimulus(0, 2'b00, 1, 1, 0);
    checkOutput("t2_empty_flush", 32'(frame_valid), 32'd0);

    // atom and flush in the same cycle at count 2
    applyStimulus(1, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b10, 1, 1, 0);
    checkOutput("t3_buf", 32'(frame_buffer), 32'h25);
    checkOutput("t3_cnt", 32'(frame_count), 32'd3);
    applyStimulus(0, 2'b00, 0, 1, 0);

    // consumer stalled: 30 atoms fill slot and accumulator, 2 more are lost
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b01, 0, 0, 0);
    checkOutput("t4_held_buf", 32'(frame_buffer), 32'h2AAAAAAA);
    checkOutput("t4_acc_full", 32'(dct_count), 32'd15);
    applyStimulus(1, 2'b11, 0, 0, 0);
    applyStimulus(1, 2'b10, 0, 0, 0);
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    checkOutput("t4_still_held", 32'(frame_buffer), 32'h2AAAAAAA);
`ifdef DCT_DROP_CNT_EN
    checkOutput("t4_drop_count", 32'(drop_count), 32'd2);
`endif
    applyStimulus(0, 2'b00, 0, 1, 0);
    checkOutput("t4_second_valid", 32'(frame_valid), 32'd1);
    checkOutput("t4_second_buf", 32'(frame_buffer), 32'h15555555);
    checkOutput("t4_second_cnt", 32'(frame_count), 32'd15);

    // overflow clear without and with a concurrent drop
    applyStimulus(0, 2'b00, 0, 1, 1);
    checkOutput("t6_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 30; i++) applyStimulus(1, 2'b11, 0, 0, 0);
    applyStimulus(1, 2'b01, 0, 0, 1);
    checkOutput("t6_clr_during_drop", 32'(overflow), 32'd1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("t6_clr_after", 32'(overflow), 32'd0);
    applyStimulus(0, 2'b00, 0, 1, 0);
    applyStimulus(0, 2'b00, 0, 1, 0);

    // reset at count 7 with a frame pending in the slot
    applyStimulus(1, 2'b10, 0, 0, 0);
    applyStimulus(1, 2'b01, 1, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 2'b11, 0, 0, 0);
    checkOutput("t5_pending", 32'(frame_valid), 32'd1);
    checkOutput("t5_cnt7", 32'(dct_count), 32'd7);
    applyReset();
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b10, 0, 1, 0);
    checkOutput("t5_clean_buf", 32'(frame_buffer), 32'h2AAAAAAA);
    checkOutput("t5_clean_cnt", 32'(frame_count), 32'd15);

    // random traffic with phases of varying consumer readiness
    for (int phase = 0; phase < 6; phase++) begin
      readyPct = (phase % 3 == 0) ? 90 : ((phase % 3 == 1) ? 40 : 10);
      for (int i = 0; i < 250; i++) begin
        applyStimulus(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                      bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 99) < readyPct),
                      bit'($urandom_range(0, 19) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
